// File: rtl/dcd_pwl_cal.sv
// dcd_pwl_cal: segmented piecewise-polynomial LMS calibrator.
// Evaluation and update run one polynomial term per cycle.
module dcd_pwl_cal #(
    parameter int NSEG_LOG2 = 3,
    parameter int NX        = 3,
    parameter int WX        = 16,
    parameter int WC        = 24,
    parameter int FC        = 16
) (
    input  logic                   CLK,
    input  logic                   NRST,
    input  logic                   EN,
    input  logic                   CLR,
    input  logic                   FREEZE,
    input  logic [4:0]             MU_SHIFT,
    input  logic [WX-1:0]          X,
    input  logic                   X_VALID,
    output logic                   X_READY,
    output logic signed [WC-1:0]   Y,
    output logic                   Y_VALID,
    input  logic signed [WC-1:0]   ERR,
    input  logic                   ERR_VALID,
    input  logic [NSEG_LOG2-1:0]   RD_SEG,
    input  logic [$clog2(NX)-1:0]  RD_K,
    output logic signed [WC-1:0]   RD_COEF,
    output logic                   SAT,
    output logic                   BUSY
);
    localparam int NSEG = 1 << NSEG_LOG2;
    localparam int KW   = $clog2(NX);
    localparam int AW   = WC + 4;
    localparam int MW   = WC + WX + 2;
    localparam int FW   = WX - NSEG_LOG2;

    if (FC >= WC) begin : g_fc_chk
        $error("FC must be smaller than WC");
    end

    typedef enum logic [1:0] {IDLE, EVAL, WAIT_ERR, UPDATE} state_t;

    state_t                 state;
    logic signed [WC-1:0]   c [NSEG][NX];
    logic [WX:0]            pk [NX];
    logic [NSEG_LOG2-1:0]   seg;
    logic [WX-1:0]          xf;
    logic [WX:0]            p;
    logic [KW-1:0]          k;
    logic signed [AW-1:0]   acc;
    logic signed [WC-1:0]   err_q;

    logic                   last_k;
    logic signed [WC-1:0]   c_cur;
    logic signed [MW-1:0]   mul_e;
    logic signed [MW-1:0]   term_e;
    logic signed [AW-1:0]   acc_nxt;
    logic signed [MW-1:0]   acc_ext;
    logic [2*WX:0]          pmul;
    logic signed [MW-1:0]   mul_u;
    logic signed [MW-1:0]   dlt_u;
    logic signed [MW-1:0]   upd_sum;

    function automatic logic ovf_wc(input logic signed [MW-1:0] v);
        return !(&v[MW-1:WC-1] || !(|v[MW-1:WC-1]));
    endfunction

    function automatic logic signed [WC-1:0] sat_wc(
        input logic signed [MW-1:0] v
    );
        if (!ovf_wc(v))
            return v[WC-1:0];
        else if (v[MW-1])
            return {1'b1, {(WC-1){1'b0}}};
        else
            return {1'b0, {(WC-1){1'b1}}};
    endfunction

    assign last_k  = (k == KW'(NX - 1));
    assign c_cur   = c[seg][k];

    // Power register is Q1.WX, so the product keeps c's scale after >>> WX.
    assign mul_e   = c_cur * $signed({1'b0, p});
    assign term_e  = mul_e >>> WX;
    assign acc_nxt = acc + $signed(term_e[AW-1:0]);
    assign acc_ext = acc_nxt;
    assign pmul    = p * xf;

    assign mul_u   = err_q * $signed({1'b0, pk[k]});
    assign dlt_u   = mul_u >>> (WX + int'(MU_SHIFT));
    assign upd_sum = c_cur + dlt_u;

    assign X_READY = NRST & EN & ~CLR & (state == IDLE);
    assign BUSY    = (state != IDLE);

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state   <= IDLE;
            seg     <= '0;
            xf      <= '0;
            p       <= '0;
            k       <= '0;
            acc     <= '0;
            err_q   <= '0;
            Y       <= '0;
            Y_VALID <= 1'b0;
            SAT     <= 1'b0;
            for (int i = 0; i < NSEG; i++)
                for (int j = 0; j < NX; j++)
                    c[i][j] <= '0;
            for (int j = 0; j < NX; j++)
                pk[j] <= '0;
        end else if (CLR) begin
            state   <= IDLE;
            Y_VALID <= 1'b0;
            SAT     <= 1'b0;
            for (int i = 0; i < NSEG; i++)
                for (int j = 0; j < NX; j++)
                    c[i][j] <= '0;
        end else if (!EN) begin
            state   <= IDLE;
            Y_VALID <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (X_VALID) begin
                        seg   <= X[WX-1 -: NSEG_LOG2];
                        xf    <= {X[FW-1:0], {NSEG_LOG2{1'b0}}};
                        p     <= {1'b1, {WX{1'b0}}};
                        k     <= '0;
                        acc   <= '0;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    acc   <= acc_nxt;
                    pk[k] <= p;
                    p     <= pmul[2*WX:WX];
                    k     <= k + KW'(1);
                    if (last_k) begin
                        Y       <= sat_wc(acc_ext);
                        Y_VALID <= 1'b1;
                        if (ovf_wc(acc_ext))
                            SAT <= 1'b1;
                        state   <= WAIT_ERR;
                    end
                end
                WAIT_ERR: begin
                    if (ERR_VALID) begin
                        Y_VALID <= 1'b0;
                        if (FREEZE) begin
                            state <= IDLE;
                        end else begin
                            err_q <= ERR;
                            k     <= '0;
                            state <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    c[seg][k] <= sat_wc(upd_sum);
                    if (ovf_wc(upd_sum))
                        SAT <= 1'b1;
                    k <= k + KW'(1);
                    if (last_k)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST)
            RD_COEF <= '0;
        else if (int'(RD_K) < NX)
            RD_COEF <= c[RD_SEG][RD_K];
        else
            RD_COEF <= '0;
    end

endmodule

// File: tb/tb_dcd_pwl_cal.sv
// tb_dcd_pwl_cal: directed checks of dcd_pwl_cal against a
// plain-arithmetic segment/polynomial model.
module tb_dcd_pwl_cal;
    localparam int NS   = 3;
    localparam int NX   = 3;
    localparam int WX   = 16;
    localparam int WC   = 24;
    localparam int NSEG = 1 << NS;
    localparam longint CMAX = (64'sd1 <<< (WC - 1)) - 1;
    localparam longint CMIN = -(64'sd1 <<< (WC - 1));

    logic                   CLK = 1'b0;
    logic                   NRST = 1'b0;
    logic                   EN = 1'b0;
    logic                   CLR = 1'b0;
    logic                   FREEZE = 1'b0;
    logic [4:0]             MU_SHIFT = '0;
    logic [WX-1:0]          X = '0;
    logic                   X_VALID = 1'b0;
    logic                   X_READY;
    logic signed [WC-1:0]   Y;
    logic                   Y_VALID;
    logic signed [WC-1:0]   ERR = '0;
    logic                   ERR_VALID = 1'b0;
    logic [NS-1:0]          RD_SEG = '0;
    logic [$clog2(NX)-1:0]  RD_K = '0;
    logic signed [WC-1:0]   RD_COEF;
    logic                   SAT;
    logic                   BUSY;

    dcd_pwl_cal #(
        .NSEG_LOG2(NS), .NX(NX), .WX(WX), .WC(WC), .FC(16)
    ) dut (
        .CLK(CLK), .NRST(NRST), .EN(EN), .CLR(CLR),
        .FREEZE(FREEZE), .MU_SHIFT(MU_SHIFT),
        .X(X), .X_VALID(X_VALID), .X_READY(X_READY),
        .Y(Y), .Y_VALID(Y_VALID),
        .ERR(ERR), .ERR_VALID(ERR_VALID),
        .RD_SEG(RD_SEG), .RD_K(RD_K), .RD_COEF(RD_COEF),
        .SAT(SAT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int     checks = 0;
    int     errors = 0;
    longint mc [NSEG][NX];
    bit     msat = 1'b0;
    longint model_y = 0;
    int     x_last = 0;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic longint m_pow(int x, int k);
        longint p = 64'sd1 <<< WX;
        longint xf = longint'((x & ((1 << (WX - NS)) - 1)) << NS);
        for (int i = 0; i < k; i++)
            p = (p * xf) >> WX;
        return p;
    endfunction

    function automatic longint m_sat(longint v);
        return (v > CMAX) ? CMAX : ((v < CMIN) ? CMIN : v);
    endfunction

    function automatic longint m_eval(int x);
        int s = x >> (WX - NS);
        longint acc = 0;
        for (int k = 0; k < NX; k++)
            acc += (mc[s][k] * m_pow(x, k)) >>> WX;
        return m_sat(acc);
    endfunction

    task automatic m_update(int x, longint err, int mu, int nterms);
        int s = x >> (WX - NS);
        longint v;
        for (int k = 0; k < nterms; k++) begin
            v = mc[s][k] + ((err * m_pow(x, k)) >>> (WX + mu));
            if (m_sat(v) != v)
                msat = 1'b1;
            mc[s][k] = m_sat(v);
        end
    endtask

    task automatic m_clear();
        for (int s = 0; s < NSEG; s++)
            for (int k = 0; k < NX; k++)
                mc[s][k] = 0;
        msat = 1'b0;
    endtask

    // Y is compared against the model on every cycle it is valid.
    always @(negedge CLK) begin
        if (NRST && Y_VALID) begin
            checks++;
            if (longint'(Y) != model_y) begin
                errors++;
                $display("FAIL y_model: got %0d want %0d", Y, model_y);
            end
        end
    end

    task automatic rd(int s, int k, output longint v);
        RD_SEG = NS'(s);
        RD_K = 2'(k);
        @(posedge CLK);
        #1;
        v = RD_COEF;
    endtask

    task automatic check_all();
        longint v;
        for (int s = 0; s < NSEG; s++)
            for (int k = 0; k < NX; k++) begin
                rd(s, k, v);
                chk($sformatf("coef_s%0d_k%0d", s, k), v, mc[s][k]);
            end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!X_READY && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (!X_READY)
            chk("x_ready_timeout", 0, 1);
    endtask

    task automatic send_x(int x);
        int n;
        wait_ready();
        x_last = x;
        model_y = m_eval(x);
        X = x[WX-1:0];
        X_VALID = 1'b1;
        @(posedge CLK);
        #1;
        X_VALID = 1'b0;
        n = 0;
        while (!Y_VALID && n < 10) begin
            chk("busy_eval", BUSY, 1);
            @(posedge CLK);
            #1;
            n++;
        end
        chk("y_latency", n, NX);
    endtask

    task automatic send_err(longint err, bit frz, int mu);
        ERR = err[WC-1:0];
        FREEZE = frz;
        MU_SHIFT = mu[4:0];
        ERR_VALID = 1'b1;
        @(posedge CLK);
        #1;
        ERR_VALID = 1'b0;
        chk("y_valid_drop", Y_VALID, 0);
        if (frz) begin
            chk("ready_after_freeze", X_READY, 1);
        end else begin
            m_update(x_last, err, mu, NX);
            repeat (NX) begin
                chk("busy_upd", BUSY, 1);
                chk("ready_upd", X_READY, 0);
                @(posedge CLK);
                #1;
            end
            chk("ready_after_upd", X_READY, 1);
            chk("sat_after_upd", SAT, msat);
        end
        FREEZE = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        longint v;
        m_clear();

        // Reset state, with EN already high.
        EN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_x_ready", X_READY, 0);
        chk("rst_y", Y, 0);
        chk("rst_y_valid", Y_VALID, 0);
        chk("rst_sat", SAT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_rd_coef", RD_COEF, 0);
        NRST = 1'b1;
        @(posedge CLK);
        #1;
        chk("ready_after_rst", X_READY, 1);

        // Post-reset evaluate, then update with +1.0.
        send_x('hB000);
        chk("y_first", Y, 0);
        send_err('h010000, 1'b0, 0);
        rd(5, 0, v); chk("c5k0", v, 'h010000);
        rd(5, 1, v); chk("c5k1", v, 'h008000);
        rd(5, 2, v); chk("c5k2", v, 'h004000);
        rd(4, 0, v); chk("c4k0", v, 0);
        send_x('hB000);
        chk("y_reeval", Y, 'h015000);

        // Freeze leaves coefficients untouched.
        send_err('h010000, 1'b1, 0);
        check_all();

        // Further patterns, negative errors and step sizes.
        send_x('hB7FF);
        send_err(-'h8000, 1'b0, 2);
        send_x('h2345);
        send_err(-'h123456, 1'b0, 3);
        send_x('h2345);
        send_err('h0F0F0F, 1'b0, 1);
        send_x('hB7FF);
        send_err(0, 1'b1, 0);
        check_all();

        // Saturation on segment 0, then clear.
        repeat (3) begin
            send_x('h0000);
            send_err('h7FFFFF, 1'b0, 0);
        end
        rd(0, 0, v); chk("c0k0_sat", v, 'h7FFFFF);
        chk("sat_set", SAT, 1);
        CLR = 1'b1;
        @(posedge CLK);
        #1;
        CLR = 1'b0;
        m_clear();
        chk("sat_cleared", SAT, 0);
        check_all();

        // EN drops in the second EVAL cycle.
        wait_ready();
        X = 'hB000;
        X_VALID = 1'b1;
        @(posedge CLK);
        #1;
        X_VALID = 1'b0;
        @(posedge CLK);
        #1;
        EN = 1'b0;
        @(posedge CLK);
        #1;
        chk("abort_eval_busy", BUSY, 0);
        chk("abort_eval_yv", Y_VALID, 0);
        EN = 1'b1;
        repeat (4) begin
            @(posedge CLK);
            #1;
            chk("abort_eval_no_yv", Y_VALID, 0);
        end

        // EN drops mid-UPDATE: only term 0 is written.
        send_x('hB000);
        ERR = 'h010000;
        MU_SHIFT = '0;
        ERR_VALID = 1'b1;
        @(posedge CLK);
        #1;
        ERR_VALID = 1'b0;
        @(posedge CLK);
        #1;
        EN = 1'b0;
        @(posedge CLK);
        #1;
        chk("abort_upd_busy", BUSY, 0);
        EN = 1'b1;
        m_update('hB000, 'h010000, 0, 1);
        rd(5, 0, v); chk("abort_c5k0", v, 'h010000);
        rd(5, 1, v); chk("abort_c5k1", v, 0);
        check_all();

        // Reset pulse during UPDATE.
        send_x('hB000);
        chk("y_before_rst", Y, 'h010000);
        ERR = 'h010000;
        ERR_VALID = 1'b1;
        @(posedge CLK);
        #1;
        ERR_VALID = 1'b0;
        @(posedge CLK);
        #1;
        NRST = 1'b0;
        #2;
        chk("rst_mid_y", Y, 0);
        chk("rst_mid_yv", Y_VALID, 0);
        chk("rst_mid_busy", BUSY, 0);
        #1;
        NRST = 1'b1;
        m_clear();
        check_all();

        // ERR_VALID in IDLE is ignored.
        ERR = 'h010000;
        ERR_VALID = 1'b1;
        @(posedge CLK);
        #1;
        ERR_VALID = 1'b0;
        chk("idle_err_busy", BUSY, 0);
        chk("idle_err_yv", Y_VALID, 0);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
